ps2_scancode_filter: RTL and testbench
======================================

Name: ps2_scancode_filter

Overview:
- Sits between ps2_controller and data_control.
- Turns the raw PS/2 Set-2 byte stream into clean single-cycle key-press events for the Morse encoder.
- Resolves the E0 (extended) and F0 (break) prefixes, swallows the E1 Pause sequence and keyboard status bytes, and suppresses typematic auto-repeat.
- Aborts stale prefixes on timeout.

Parameters:
- TIMEOUT_CYCLES, 100000, clk cycles a prefix state may wait for its next byte before returning to IDLE (2 ms at 50 MHz).
- TYPEMATIC_FILTER, 1, 1 = a repeated make of the held key is dropped; 0 = every make is forwarded.

Ports:
- clk  input  1  system clock, 50 MHz
- rst  input  1  asynchronous, active-low reset
- ps2_received_data  input  8  byte from ps2_controller
- ps2_received_data_strb  input  1  one-cycle strobe; ps2_received_data is valid in the same cycle
- key_code  output  8  scancode of the event (prefix bytes stripped)
- key_extended  output  1  event was E0-prefixed
- key_released  output  1  event is a break (only ever 1 with RELEASE_EVENTS_EN)
- key_code_strb  output  1  one-cycle event strobe to data_control
- seq_error  output  1  one-cycle pulse on prefix timeout or a dropped error/status byte

Behaviour:
- Reset (rst low, asynchronous): all outputs 0, state IDLE, held_valid 0, timeout counter 0, pause counter 0.
- Latency: registered outputs. key_code_strb asserts exactly 1 cycle after the input strobe of the completing byte. key_code, key_extended and key_released hold until the next event.
- Input strobes arrive at least 2 cycles apart (PS/2 byte rate).
- Drop bytes: 00, AA, EE, FA, FC, FD, FE, FF. In IDLE these pulse seq_error, except AA/FA/EE (normal status), which are dropped silently. In any prefix state a drop byte pulses seq_error and returns to IDLE.
- States:
  - IDLE: E0 -> EXT; F0 -> BRK; E1 -> PAUSE (pause_cnt = 7); other byte -> make event (ext = 0).
  - EXT: F0 -> EXT_BRK; E0 -> stay; other byte -> make event (ext = 1), then IDLE.
  - BRK: other byte -> break handling (ext = 0), then IDLE.
  - EXT_BRK: other byte -> break handling (ext = 1), then IDLE.
  - PAUSE: each strobe decrements pause_cnt. At 0, emit a make event with key_code = E1, ext = 0 (no break ever emitted), then IDLE. Timeout does not apply in PAUSE.
- Make event:
  - If TYPEMATIC_FILTER = 1, held_valid = 1 and {ext, byte} == held: drop silently.
  - Otherwise emit, then set held = {ext, byte} and held_valid = 1.
- Break handling:
  - If {ext, byte} == held, clear held_valid.
  - With RELEASE_EVENTS_EN, emit the event with key_released = 1.
- Timeout: the counter runs only in EXT, BRK and EXT_BRK, and resets on every strobe. At TIMEOUT_CYCLES-1 it pulses seq_error and returns to IDLE; held is unchanged.
- Strobe in the same cycle as a timeout: the strobe wins and is processed in the current state.
- Rollover: a new key pressed while another is held replaces held. A break for a non-held key leaves held unchanged.

Optional Feature:
- RELEASE_EVENTS_EN defined: break sequences produce key_code_strb with key_released = 1.
- Not defined: breaks only update held state, key_released is tied 0, and data_control sees presses only.

Decomposition:
- Package ps2_codes_pkg holds:
  - scancode constants: PS2_EXT = E0, PS2_BREAK = F0, PS2_PAUSE = E1, PS2_BAT_OK = AA, PS2_ACK = FA, PS2_ECHO = EE, PS2_RESEND = FE, PS2_ERR0 = 00, PS2_ERR1 = FF;
  - the filter state enum;
  - the pause sequence length, 7.
- One natural sub-module: ps2_prefix_timer (loadable down-counter with expire pulse), reusable by ps2_controller.

Test Plan:
1. Bytes 1C -> one strobe, key_code = 1C, ext = 0, rel = 0; then 1C, 1C, 1C (typematic) -> no further strobes; then F0 1C, 1C -> second strobe with 1C.
2. E0 75 -> strobe, key_code = 75, ext = 1. Then E0 F0 75 -> held cleared, no strobe (macro off), or strobe with rel = 1, ext = 1 (macro on).
3. E1 14 77 E1 F0 14 F0 77 -> exactly one strobe, key_code = E1, after the 8th byte; no strobe for 14 or 77.
4. F0, then idle for TIMEOUT_CYCLES -> seq_error pulse at cycle TIMEOUT_CYCLES-1, state IDLE; next 29 -> strobe, key_code = 29, rel = 0.
5. AA, FA, then FF -> no strobes; seq_error only on FF. Then 32 -> strobe, key_code = 32.
6. Hold 1C, press 32, then 1C again -> strobes 1C, 32, 1C (rollover replaces held). Assert rst low mid E0 prefix -> outputs 0 at once; after release, 1C -> strobe with ext = 0.

Source files
------------

// File: rtl/ps2_codes_pkg.sv
// PS/2 Set-2 scancode constants, filter state encoding and byte classifiers
// shared by the scancode filter and the PS/2 controller.
package ps2_codes_pkg;

    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_BREAK  = 8'hF0;
    localparam logic [7:0] PS2_PAUSE  = 8'hE1;
    localparam logic [7:0] PS2_BAT_OK = 8'hAA;
    localparam logic [7:0] PS2_ACK    = 8'hFA;
    localparam logic [7:0] PS2_ECHO   = 8'hEE;
    localparam logic [7:0] PS2_RESEND = 8'hFE;
    localparam logic [7:0] PS2_ERR0   = 8'h00;
    localparam logic [7:0] PS2_ERR1   = 8'hFF;

    // Bytes that follow E1 before the Pause make is reported.
    localparam int PAUSE_SEQ_LEN = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK,
        ST_PAUSE
    } filt_state_t;

    typedef struct packed {
        logic       ext;
        logic [7:0] code;
    } key_id_t;

    function automatic logic is_drop_byte(input logic [7:0] b);
        return b inside {PS2_ERR0, PS2_BAT_OK, PS2_ECHO, PS2_ACK,
                         8'hFC, 8'hFD, PS2_RESEND, PS2_ERR1};
    endfunction

    function automatic logic is_status_byte(input logic [7:0] b);
        return b inside {PS2_BAT_OK, PS2_ACK, PS2_ECHO};
    endfunction

endpackage

// File: rtl/ps2_scancode_filter_if.sv
// Byte stream from ps2_controller in, cleaned key events out to data_control.
interface ps2_scancode_filter_if;
    logic [7:0] ps2_received_data;
    logic       ps2_received_data_strb;
    logic [7:0] key_code;
    logic       key_extended;
    logic       key_released;
    logic       key_code_strb;
    logic       seq_error;

    modport master (
        output ps2_received_data, ps2_received_data_strb,
        input  key_code, key_extended, key_released, key_code_strb, seq_error
    );

    modport slave (
        input  ps2_received_data, ps2_received_data_strb,
        output key_code, key_extended, key_released, key_code_strb, seq_error
    );
endinterface

// File: rtl/ps2_prefix_timer.sv
// Loadable down-counter; expire is high while enabled and counted out,
// unless a load arrives in the same cycle.
module ps2_prefix_timer #(
    parameter int W = 17
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         expire
);
    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (en && cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign expire = en && !load && (cnt == '0);
endmodule

// File: rtl/ps2_scancode_filter.sv
// PS/2 Set-2 byte stream to single-cycle key events with prefix resolution,
// typematic suppression and prefix timeout. Macro RELEASE_EVENTS_EN adds break events.
module ps2_scancode_filter
    import ps2_codes_pkg::*;
#(
    parameter int TIMEOUT_CYCLES   = 100000,
    parameter bit TYPEMATIC_FILTER = 1'b1
) (
    input logic               clk,
    input logic               rst,
    ps2_scancode_filter_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    filt_state_t state;
    logic [2:0]  pause_cnt;
    key_id_t     held, req;
    logic        held_valid, held_hit, mk_req, bk_req, drop;
    logic        in_prefix, tmr_load, tmr_expire;
    logic [7:0]  rx;
    logic        rx_strb;
    logic [7:0]  key_code_q;
    logic        key_ext_q, key_rel_q, key_strb_q, seq_err_q;

    assign rx        = bus.ps2_received_data;
    assign rx_strb   = bus.ps2_received_data_strb;
    assign drop      = is_drop_byte(rx);
    assign held_hit  = held_valid && (held == req);
    assign in_prefix = state inside {ST_EXT, ST_BRK, ST_EXT_BRK};
    // Idle and pause keep the timer preloaded so a new prefix starts fresh.
    assign tmr_load  = rx_strb || !in_prefix;

    ps2_prefix_timer #(.W(TW)) u_tmr (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (TW'(TIMEOUT_CYCLES - 1)),
        .en       (in_prefix),
        .expire   (tmr_expire)
    );

    always_comb begin
        mk_req   = 1'b0;
        bk_req   = 1'b0;
        req.ext  = 1'b0;
        req.code = rx;
        if (rx_strb && !drop) begin
            case (state)
                ST_IDLE:    mk_req = !(rx inside {PS2_EXT, PS2_BREAK, PS2_PAUSE});
                ST_EXT: begin
                    mk_req  = !(rx inside {PS2_EXT, PS2_BREAK});
                    req.ext = 1'b1;
                end
                ST_BRK:     bk_req = 1'b1;
                ST_EXT_BRK: begin
                    bk_req  = 1'b1;
                    req.ext = 1'b1;
                end
                ST_PAUSE: begin
                    mk_req   = (pause_cnt == 3'd1);
                    req.code = PS2_PAUSE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            pause_cnt  <= '0;
            held       <= '0;
            held_valid <= 1'b0;
            key_code_q <= '0;
            key_ext_q  <= 1'b0;
            key_rel_q  <= 1'b0;
            key_strb_q <= 1'b0;
            seq_err_q  <= 1'b0;
        end else begin
            key_strb_q <= 1'b0;
            seq_err_q  <= 1'b0;

            if (mk_req && !(TYPEMATIC_FILTER && held_hit)) begin
                key_strb_q <= 1'b1;
                key_code_q <= req.code;
                key_ext_q  <= req.ext;
                key_rel_q  <= 1'b0;
                held       <= req;
                held_valid <= 1'b1;
            end

            // A break for a key other than the held one leaves rollover state alone.
            if (bk_req) begin
                if (held_hit)
                    held_valid <= 1'b0;
`ifdef RELEASE_EVENTS_EN
                key_strb_q <= 1'b1;
                key_code_q <= req.code;
                key_ext_q  <= req.ext;
                key_rel_q  <= 1'b1;
`endif
            end

            if (rx_strb) begin
                if (drop) begin
                    seq_err_q <= (state != ST_IDLE) || !is_status_byte(rx);
                    state     <= ST_IDLE;
                end else begin
                    case (state)
                        ST_IDLE: begin
                            if (rx == PS2_EXT)
                                state <= ST_EXT;
                            else if (rx == PS2_BREAK)
                                state <= ST_BRK;
                            else if (rx == PS2_PAUSE) begin
                                state     <= ST_PAUSE;
                                pause_cnt <= 3'(PAUSE_SEQ_LEN);
                            end
                        end
                        ST_EXT: begin
                            if (rx == PS2_BREAK)
                                state <= ST_EXT_BRK;
                            else if (rx != PS2_EXT)
                                state <= ST_IDLE;
                        end
                        ST_PAUSE: begin
                            pause_cnt <= pause_cnt - 3'd1;
                            if (pause_cnt == 3'd1)
                                state <= ST_IDLE;
                        end
                        default: state <= ST_IDLE;
                    endcase
                end
            end else if (tmr_expire) begin
                seq_err_q <= 1'b1;
                state     <= ST_IDLE;
            end
        end
    end

    assign bus.key_code      = key_code_q;
    assign bus.key_extended  = key_ext_q;
    assign bus.key_released  = key_rel_q;
    assign bus.key_code_strb = key_strb_q;
    assign bus.seq_error     = seq_err_q;
endmodule

// File: tb/tb_ps2_scancode_filter.sv
// Bench for ps2_scancode_filter: prefix-queue reference model checked every cycle,
// directed scenarios with literal event expectations, then randomized byte traffic.
module tb_ps2_scancode_filter;
    localparam int T = 24;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ps2_scancode_filter_if bus();

    ps2_scancode_filter #(.TIMEOUT_CYCLES(T), .TYPEMATIC_FILTER(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int n_err_seen = 0;
    logic [9:0] dut_ev[$];

    // Expected outputs for the cycle following the next rising edge.
    logic [7:0] e_code = '0;
    logic       e_ext = 1'b0, e_rel = 1'b0, e_strb = 1'b0, e_err = 1'b0;
    logic [7:0] pfx[$];
    int         held_key = -1;
    int         wait_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h want %h", nm, $time, act, exp);
        end
    endtask

    function automatic bit tb_drop(input logic [7:0] b);
        return b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF};
    endfunction

    task automatic model_reset();
        e_code = '0; e_ext = 0; e_rel = 0; e_strb = 0; e_err = 0;
        pfx.delete(); held_key = -1; wait_cnt = 0;
    endtask

    task automatic m_make(input bit ext, input logic [7:0] c);
        int key = (int'(ext) << 8) | int'(c);
        if (held_key == key) return;
        e_strb = 1; e_code = c; e_ext = ext; e_rel = 0;
        held_key = key;
    endtask

    task automatic m_break(input bit ext, input logic [7:0] c);
        int key = (int'(ext) << 8) | int'(c);
        if (held_key == key) held_key = -1;
`ifdef RELEASE_EVENTS_EN
        e_strb = 1; e_code = c; e_ext = ext; e_rel = 1;
`endif
    endtask

    task automatic model_step(input bit s, input logic [7:0] b);
        if (!rst) begin
            model_reset();
            return;
        end
        e_strb = 0;
        e_err  = 0;
        if (s) begin
            wait_cnt = 0;
            if (tb_drop(b)) begin
                e_err = (pfx.size() != 0) || !(b inside {8'hAA, 8'hFA, 8'hEE});
                pfx.delete();
            end else if (pfx.size() == 0) begin
                if (b inside {8'hE0, 8'hF0, 8'hE1}) pfx.push_back(b);
                else m_make(1'b0, b);
            end else if (pfx[0] == 8'hE1) begin
                pfx.push_back(b);
                if (pfx.size() == 8) begin
                    m_make(1'b0, 8'hE1);
                    pfx.delete();
                end
            end else if (pfx.size() == 1 && pfx[0] == 8'hE0) begin
                if (b == 8'hF0) pfx.push_back(b);
                else if (b != 8'hE0) begin
                    m_make(1'b1, b);
                    pfx.delete();
                end
            end else begin
                m_break(pfx[0] == 8'hE0, b);
                pfx.delete();
            end
        end else if (pfx.size() != 0 && pfx[0] != 8'hE1) begin
            wait_cnt++;
            if (wait_cnt == T) begin
                e_err = 1;
                pfx.delete();
            end
        end
    endtask

    task automatic step(input bit s, input logic [7:0] b);
        @(negedge clk);
        bus.ps2_received_data      = b;
        bus.ps2_received_data_strb = s;
        model_step(s, b);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 8'h00);
    endtask

    task automatic send(input logic [7:0] b);
        step(1'b1, b);
        step(1'b0, 8'h00);
    endtask

    task automatic ev_check(input string nm, input int mark, input int n, input logic [9:0] last);
        chk({nm, " count"}, 32'(dut_ev.size() - mark), 32'(n));
        if (n > 0 && dut_ev.size() > 0)
            chk({nm, " last"}, 32'(dut_ev[$]), 32'(last));
    endtask

    always @(posedge clk) begin
        #1;
        chk("cycle", {bus.key_code_strb, bus.seq_error, bus.key_extended, bus.key_released, bus.key_code},
                     {e_strb, e_err, e_ext, e_rel, e_code});
        if (bus.key_code_strb)
            dut_ev.push_back({bus.key_extended, bus.key_released, bus.key_code});
        if (bus.seq_error)
            n_err_seen++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int mark, emark;
        logic [7:0] makes[6];
        logic [7:0] drops[8];
        logic [7:0] b;
        makes = '{8'h1C, 8'h32, 8'h29, 8'h75, 8'h14, 8'h77};
        drops = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF};

        bus.ps2_received_data      = 8'h00;
        bus.ps2_received_data_strb = 1'b0;
        #3 rst = 1'b0;
        #1 chk("reset outputs", {bus.key_code_strb, bus.seq_error, bus.key_extended, bus.key_released, bus.key_code}, 0);
        idle(3);
        rst = 1'b1;
        idle(2);

        // Typematic repeats dropped, make after break forwarded again.
        mark = dut_ev.size();
        send(8'h1C); send(8'h1C); send(8'h1C); send(8'h1C);
        send(8'hF0); send(8'h1C); send(8'h1C);
`ifdef RELEASE_EVENTS_EN
        ev_check("typematic", mark, 3, 10'h01C);
`else
        ev_check("typematic", mark, 2, 10'h01C);
`endif

        mark = dut_ev.size();
        send(8'hE0); send(8'h75);
        ev_check("ext make", mark, 1, 10'h275);
        mark = dut_ev.size();
        send(8'hE0); send(8'hF0); send(8'h75);
`ifdef RELEASE_EVENTS_EN
        ev_check("ext break", mark, 1, 10'h375);
`else
        ev_check("ext break", mark, 0, 10'h000);
`endif
        mark = dut_ev.size();
        send(8'hE0); send(8'h75);
        ev_check("ext remake", mark, 1, 10'h275);

        mark = dut_ev.size();
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0);
        ev_check("pause partial", mark, 0, 10'h000);
        send(8'h77);
        ev_check("pause", mark, 1, 10'h0E1);

        mark = dut_ev.size(); emark = n_err_seen;
        send(8'hF0);
        idle(T + 2);
        chk("timeout err", 32'(n_err_seen - emark), 1);
        ev_check("timeout", mark, 0, 10'h000);
        send(8'h29);
        ev_check("after timeout", mark, 1, 10'h029);

        mark = dut_ev.size(); emark = n_err_seen;
        send(8'hAA); send(8'hFA); send(8'hFF);
        chk("status err", 32'(n_err_seen - emark), 1);
        ev_check("status", mark, 0, 10'h000);
        send(8'h32);
        ev_check("after status", mark, 1, 10'h032);

        mark = dut_ev.size();
        send(8'h1C); send(8'h32); send(8'h1C);
        ev_check("rollover", mark, 3, 10'h01C);

        send(8'hE0);
        #1 rst = 1'b0;
        model_reset();
        #1 chk("async reset", {bus.key_code_strb, bus.seq_error, bus.key_extended, bus.key_released, bus.key_code}, 0);
        idle(3);
        rst = 1'b1;
        idle(1);
        mark = dut_ev.size();
        send(8'h1C);
        ev_check("post reset", mark, 1, 10'h01C);

        for (int i = 0; i < 2500; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 35)      b = makes[$urandom_range(0, 5)];
            else if (r < 50) b = 8'hE0;
            else if (r < 65) b = 8'hF0;
            else if (r < 70) b = 8'hE1;
            else if (r < 78) b = drops[$urandom_range(0, 7)];
            else             b = 8'($urandom);
            send(b);
            if ($urandom_range(0, 9) == 0) idle($urandom_range(T - 3, T + 2));
            else                           idle($urandom_range(0, 2));
        end
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
